axi_cmd_master: RTL and testbench

AXI_CMD_MASTER -- requirements
Module: axi_cmd_master

---
 rtl/axi_cmd_master.sv | 175 +++++++++++++++++
 tb/tb_axi_cmd_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_master.sv
// rtl/axi_cmd_master.sv - single-burst AXI-style command master with pass-through data streams
// One command at a time: address phase, data beats streamed combinationally, then completion pulse.
module axi_cmd_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk_100_mhz,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic              done,
   output logic [1:0]        resp,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        beat_q, beat_d;
   logic              mism_q, mism_d;
   logic [1:0]        resp_q, resp_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              tmo_hit, w_hs, r_hs, hs, waiting;

   always_ff @(posedge clk_100_mhz) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         mism_q  <= 1'b0;
         resp_q  <= 2'b00;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         mism_q  <= mism_d;
         resp_q  <= resp_d;
         tmo_q   <= tmo_d;
      end
   end

   // All bus-facing controls decode from the registered state, so a reset or timeout drops them on the next edge.
   assign cmd_ready = (state_q == IDLE);
   assign awvalid   = (state_q == AW);
   assign awaddr    = addr_q;
   assign wvalid    = (state_q == W) & wr_valid;
   assign wdata     = (state_q == W) ? wr_data : '0;
   assign wr_ready  = (state_q == W) & wready;
   assign wlast     = (state_q == W) & (beat_q == len_q);
   assign bready    = (state_q == B);
   assign arvalid   = (state_q == AR);
   assign araddr    = addr_q;
   assign rready    = (state_q == R) & rd_ready;
   assign rd_valid  = (state_q == R) & rvalid;
   assign rd_data   = (state_q == R) ? rdata : '0;
   assign rd_last   = (state_q == R) & rlast;
   assign done      = (state_q == DONE);
   assign resp      = resp_q;

   assign w_hs    = wvalid & wready;
   assign r_hs    = rd_valid & rready;
   assign tmo_hit = (tmo_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      beat_d  = beat_q;
      mism_d  = mism_q;
      resp_d  = resp_q;
      tmo_d   = '0;
      hs      = 1'b0;
      waiting = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               beat_d  = '0;
               mism_d  = 1'b0;
               state_d = cmd_write ? AW : AR;
            end
         end
         AW: begin
            waiting = 1'b1;
            if (awready) begin
               hs      = 1'b1;
               state_d = W;
            end
         end
         W: begin
            waiting = 1'b1;
            if (w_hs) begin
               hs     = 1'b1;
               beat_d = beat_q + 8'd1;
               if (wlast) state_d = B;
            end
         end
         B: begin
            waiting = 1'b1;
            if (bvalid) begin
               hs      = 1'b1;
               resp_d  = bresp;
               state_d = DONE;
            end
         end
         AR: begin
            waiting = 1'b1;
            if (arready) begin
               hs      = 1'b1;
               state_d = R;
            end
         end
         R: begin
            waiting = 1'b1;
            if (r_hs) begin
               hs     = 1'b1;
               beat_d = beat_q + 8'd1;
               // A full-length burst without rlast is sticky: extra beats still drain until rlast.
               if ((beat_q == len_q) && !rlast) mism_d = 1'b1;
               if (rlast) begin
                  state_d = DONE;
                  resp_d  = (mism_q || (beat_q != len_q)) ? 2'b10 : 2'b00;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (waiting && !hs) begin
         if (tmo_hit) begin
            resp_d  = 2'b11;
            state_d = DONE;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_cmd_master.sv
// tb/tb_axi_cmd_master.sv - scoreboard bench for axi_cmd_master with randomized slave timing
// Driver tasks play both command source and bus slave; a negedge monitor pops expectations.
module tb_axi_cmd_master;

   localparam int TMO = 16;

   logic        clk_100_mhz = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_last, rd_ready;
   logic        done;
   logic [1:0]  resp;
   logic [31:0] awaddr;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic        wlast, wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [31:0] araddr;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic        rlast, rvalid, rready;

   int checks = 0;
   int errors = 0;
   int viol   = 0;
   bit busy   = 1'b0;

   logic [31:0] exp_aw_q[$];
   logic [31:0] exp_ar_q[$];
   logic [32:0] exp_w_q[$];
   logic [32:0] exp_rd_q[$];
   logic [1:0]  exp_resp_q[$];

   always #5 clk_100_mhz = ~clk_100_mhz;

   axi_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk_100_mhz(clk_100_mhz), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
      .done(done), .resp(resp),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   task automatic tick();
      @(posedge clk_100_mhz);
      #1;
   endtask

   task automatic half();
      @(negedge clk_100_mhz);
      if (busy && cmd_ready) viol++;
   endtask

   // Scoreboard monitor: every handshake or completion seen on the DUT pops one expectation.
   initial begin
      forever begin
         @(negedge clk_100_mhz);
         if (rst === 1'b0) begin
            if (awvalid && awready) begin
               if (exp_aw_q.size() == 0) fail_now("unexpected_aw", awaddr);
               else chk("awaddr", awaddr, exp_aw_q.pop_front());
            end
            if (arvalid && arready) begin
               if (exp_ar_q.size() == 0) fail_now("unexpected_ar", araddr);
               else chk("araddr", araddr, exp_ar_q.pop_front());
            end
            if (wvalid && wready) begin
               if (exp_w_q.size() == 0) fail_now("unexpected_w", {wlast, wdata});
               else chk("w_last_data", {wlast, wdata}, exp_w_q.pop_front());
            end
            if (rd_valid && rd_ready) begin
               if (exp_rd_q.size() == 0) fail_now("unexpected_rd", {rd_last, rd_data});
               else chk("rd_last_data", {rd_last, rd_data}, exp_rd_q.pop_front());
            end
            if (done) begin
               if (exp_resp_q.size() == 0) fail_now("unexpected_done", resp);
               else chk("resp", resp, exp_resp_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l, input bit hold);
      int w = 0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
      half();
      while (!cmd_ready && w < 8) begin
         tick();
         w++;
         half();
      end
      chk("cmd_accept", cmd_ready, 1);
      tick();
      busy = 1'b1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int w = 0;
      half();
      while (!done && w < 8) begin
         tick();
         w++;
         half();
      end
      if (!done) fail_now("done_timeout", w);
      tick();
      busy = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [31:0] d0,
                           input int aw_d, input logic [1:0] br, input bit hold, input int rst_at);
      logic [31:0] dat[$];
      int k, cyc, stall, cnt, bd;
      bit hs;
      for (int i = 0; i <= int'(l); i++) dat.push_back((i == 0) ? d0 : $urandom);
      exp_aw_q.push_back(a);
      for (int i = 0; i <= int'(l); i++)
         if (rst_at < 0 || i < rst_at) exp_w_q.push_back({i == int'(l), dat[i]});
      if (rst_at < 0) exp_resp_q.push_back(br);
      issue(1'b1, a, l, hold);
      cnt = 0;
      hs  = 1'b0;
      while (!hs && cnt < 32) begin
         awready = (cnt >= aw_d);
         half();
         if (cnt == 0) chk("aw_latency", awvalid, 1);
         hs = awvalid && awready;
         tick();
         cnt++;
      end
      awready = 1'b0;
      if (!hs) fail_now("aw_handshake_timeout", cnt);
      k = 0;
      cyc = 0;
      stall = $urandom_range(0, 3);
      while (k <= int'(l) && cyc < 64) begin
         wr_data = dat[k];
         if (k == rst_at) begin
            rst = 1'b1;
            wr_valid = 1'b1;
            wready = 1'b1;
            half();
            tick();
            rst = 1'b0;
            busy = 1'b0;
            half();
            chk("rst_wvalid", wvalid, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
            tick();
            wr_valid = 1'b0;
            wready = 1'b0;
            cnt = 0;
            repeat (20) begin
               half();
               cnt += int'(done);
               tick();
            end
            chk("rst_no_done", cnt, 0);
            return;
         end
         if (stall == 0) begin
            wr_valid = 1'b1;
            wready = 1'b1;
         end else begin
            wr_valid = 1'($urandom);
            wready = wr_valid ? 1'b0 : 1'($urandom);
         end
         half();
         if (wvalid && wready) begin
            k++;
            stall = $urandom_range(0, 3);
         end else if (stall > 0) stall--;
         tick();
         cyc++;
      end
      wr_valid = 1'b0;
      wready = 1'b0;
      if (k <= int'(l)) fail_now("w_beats_timeout", k);
      cnt = 0;
      hs = 1'b0;
      bd = $urandom_range(0, 3);
      while (!hs && cnt < 32) begin
         bvalid = (cnt >= bd);
         bresp = br;
         half();
         hs = bvalid && bready;
         tick();
         cnt++;
      end
      bvalid = 1'b0;
      if (!hs) fail_now("b_handshake_timeout", cnt);
      wait_done();
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int ns,
                          input int ar_d, input bit toggle, input bit hold);
      logic [31:0] dat[$];
      int k, cyc, stall, cnt;
      bit hs;
      for (int i = 0; i < ns; i++) begin
         dat.push_back($urandom);
         exp_rd_q.push_back({i == ns - 1, dat[i]});
      end
      exp_ar_q.push_back(a);
      exp_resp_q.push_back((ns == int'(l) + 1) ? 2'b00 : 2'b10);
      issue(1'b0, a, l, hold);
      cnt = 0;
      hs = 1'b0;
      while (!hs && cnt < 32) begin
         arready = (cnt >= ar_d);
         half();
         if (cnt == 0) chk("ar_latency", arvalid, 1);
         hs = arvalid && arready;
         tick();
         cnt++;
      end
      arready = 1'b0;
      if (!hs) fail_now("ar_handshake_timeout", cnt);
      k = 0;
      cyc = 0;
      stall = $urandom_range(0, 3);
      while (k < ns && cyc < 96) begin
         rdata = dat[k];
         rlast = (k == ns - 1);
         if (toggle) begin
            rvalid = 1'b1;
            rd_ready = ~rd_ready;
         end else if (stall == 0) begin
            rvalid = 1'b1;
            rd_ready = 1'b1;
         end else begin
            rvalid = 1'($urandom);
            rd_ready = rvalid ? 1'b0 : 1'($urandom);
         end
         half();
         if (rvalid && rready) begin
            k++;
            stall = $urandom_range(0, 3);
         end else if (stall > 0) stall--;
         tick();
         cyc++;
      end
      rvalid = 1'b0;
      rlast = 1'b0;
      rd_ready = 1'b0;
      if (k < ns) fail_now("r_beats_timeout", k);
      wait_done();
   endtask

   task automatic do_write_tmo(input logic [31:0] a);
      int cnt = 0;
      exp_resp_q.push_back(2'b11);
      issue(1'b1, a, 8'd3, 1'b0);
      awready = 1'b0;
      half();
      while (awvalid && cnt < 40) begin
         cnt++;
         tick();
         half();
      end
      chk("tmo_awvalid_cycles", cnt, TMO);
      chk("tmo_done", done, 1);
      tick();
      busy = 1'b0;
   endtask

   initial begin
      logic [7:0] rl;
      int rns;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
      arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
      repeat (3) tick();
      half();
      chk("reset_outputs", {cmd_ready, awvalid, wvalid, wlast, bready, arvalid, rready,
                            done, resp, rd_valid, rd_last, wr_ready}, 13'h1000);
      tick();
      rst = 1'b0;
      tick();

      do_write(32'h0000_1000, 8'd0, 32'h0000_0005, 2, 2'b00, 1'b0, -1);
      do_read(32'h0000_2000, 8'd3, 4, 1, 1'b1, 1'b0);
      do_read(32'h0000_3000, 8'd3, 2, 0, 1'b0, 1'b0);
      do_write(32'h0000_4000, 8'd3, $urandom, 1, 2'b01, 1'b1, -1);
      do_read(32'h0000_5000, 8'd1, 2, 0, 1'b0, 1'b0);
      do_write_tmo(32'h0000_6000);
      do_write(32'h0000_7000, 8'd7, $urandom, 0, 2'b00, 1'b0, 2);

      for (int n = 0; n < 24; n++) begin
         rl = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            do_write($urandom, rl, $urandom, $urandom_range(0, 3), 2'($urandom),
                     1'($urandom_range(0, 1)), -1);
         end else begin
            rns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(rl) + 3) : int'(rl) + 1;
            do_read($urandom, rl, rns, $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
         end
      end
      cmd_valid = 1'b0;
      repeat (4) tick();

      chk("exp_aw_drained", exp_aw_q.size(), 0);
      chk("exp_ar_drained", exp_ar_q.size(), 0);
      chk("exp_w_drained", exp_w_q.size(), 0);
      chk("exp_rd_drained", exp_rd_q.size(), 0);
      chk("exp_resp_drained", exp_resp_q.size(), 0);
      chk("cmd_ready_while_busy", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
